// File: rtl/dma_copy_pkg.sv
// rtl/dma_copy_pkg.sv - shared register offsets and fsm state encoding for dma_copy
package dma_copy_pkg;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } state_t;

endpackage

// File: rtl/dma_copy_regs.sv
// rtl/dma_copy_regs.sv - dma_copy register file and config-port response
module dma_copy_regs
    import dma_copy_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    input  logic                    busy_i,
    input  logic                    done_set_i,
    input  logic                    err_set_i,
    output logic                    start_o,
    output logic [AddressWidth-1:0] src_o,
    output logic [AddressWidth-1:0] dst_o,
    output logic [LenWidth-1:0]     len_o,
    output logic                    irq_o
);

    logic [AddressWidth-1:0] r_src;
    logic [AddressWidth-1:0] r_dst;
    logic [LenWidth-1:0]     r_len;
    logic                    r_irq_en;
    logic                    r_done;
    logic                    r_err;
    logic                    r_rvalid;
    logic [DataWidth-1:0]    r_rdata;

    logic [2:0]           w_off;
    logic                 w_wr;
    logic                 w_cfg_wr;
    logic                 w_w1c_done;
    logic                 w_w1c_err;
    logic [DataWidth-1:0] w_mask;
    logic [DataWidth-1:0] w_src_new;
    logic [DataWidth-1:0] w_dst_new;
    logic [DataWidth-1:0] w_len_new;
    logic [DataWidth-1:0] w_rd_mux;
    logic                 w_unused_addr;

    assign w_off         = addr_i[4:2];
    assign w_unused_addr = ^{addr_i[AddressWidth-1:5], addr_i[1:0]};
    assign w_wr          = req_i && we_i;
    // Configuration registers are frozen while a transfer runs; STATUS is not.
    assign w_cfg_wr      = w_wr && !busy_i;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DataWidth; i++) begin
            w_mask[i] = (i < 32) && be_i[(i / 8) % 4];
        end
    end

    assign w_src_new = (DataWidth'(r_src) & ~w_mask) | (wdata_i & w_mask);
    assign w_dst_new = (DataWidth'(r_dst) & ~w_mask) | (wdata_i & w_mask);
    assign w_len_new = (DataWidth'(r_len) & ~w_mask) | (wdata_i & w_mask);

    assign start_o    = w_cfg_wr && (w_off == REG_CTRL) && be_i[0] && wdata_i[0];
    assign w_w1c_done = w_wr && (w_off == REG_STATUS) && be_i[0] && wdata_i[1];
    assign w_w1c_err  = w_wr && (w_off == REG_STATUS) && be_i[0] && wdata_i[2];

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            REG_SRC:    w_rd_mux = DataWidth'(r_src);
            REG_DST:    w_rd_mux = DataWidth'(r_dst);
            REG_LEN:    w_rd_mux = DataWidth'(r_len);
            REG_CTRL:   w_rd_mux = DataWidth'({r_irq_en, 1'b0});
            REG_STATUS: w_rd_mux = DataWidth'({r_err, r_done, busy_i});
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= (req_i && !we_i) ? w_rd_mux : '0;
            if (w_cfg_wr && (w_off == REG_SRC)) r_src <= {w_src_new[AddressWidth-1:2], 2'b00};
            if (w_cfg_wr && (w_off == REG_DST)) r_dst <= {w_dst_new[AddressWidth-1:2], 2'b00};
            if (w_cfg_wr && (w_off == REG_LEN)) r_len <= w_len_new[LenWidth-1:0];
            if (w_cfg_wr && (w_off == REG_CTRL) && be_i[0]) r_irq_en <= wdata_i[1];
            // Hardware set has priority over both W1C and the clear-on-start.
            r_done <= done_set_i || (r_done && !w_w1c_done && !start_o);
            r_err  <= err_set_i  || (r_err  && !w_w1c_err  && !start_o);
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = 1'b0;
    assign src_o    = r_src;
    assign dst_o    = r_dst;
    assign len_o    = r_len;
    assign irq_o    = r_done && r_irq_en;

endmodule

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - word-by-word memory copy engine with one outstanding host transaction
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    host_req_o,
    output logic                    host_we_o,
    output logic [3:0]              host_be_o,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic                    host_gnt_i,
    input  logic                    host_rvalid_i,
    input  logic [DataWidth-1:0]    host_rdata_i,
    input  logic                    host_err_i,
    output logic                    irq_o
);

    state_t                  r_state;
    logic [AddressWidth-1:0] r_src;
    logic [AddressWidth-1:0] r_dst;
    logic [LenWidth-1:0]     r_count;
    logic [DataWidth-1:0]    r_data;

    logic                    w_busy;
    logic                    w_start;
    logic                    w_done_set;
    logic                    w_err_set;
    logic [AddressWidth-1:0] w_cfg_src;
    logic [AddressWidth-1:0] w_cfg_dst;
    logic [LenWidth-1:0]     w_cfg_len;

    assign w_busy = (r_state != ST_IDLE);

    dma_copy_regs #(
        .AddressWidth (AddressWidth),
        .DataWidth    (DataWidth),
        .LenWidth     (LenWidth)
    ) u_regs (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .busy_i     (w_busy),
        .done_set_i (w_done_set),
        .err_set_i  (w_err_set),
        .start_o    (w_start),
        .src_o      (w_cfg_src),
        .dst_o      (w_cfg_dst),
        .len_o      (w_cfg_len),
        .irq_o      (irq_o)
    );

    always_comb begin
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            ST_IDLE: w_done_set = w_start && (w_cfg_len == '0);
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (host_rvalid_i && host_err_i) begin
                    w_done_set = 1'b1;
                    w_err_set  = 1'b1;
                end else if (host_rvalid_i && (r_state == ST_WR_WAIT) && (r_count == LenWidth'(1))) begin
                    w_done_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && (w_cfg_len != '0)) begin
                        r_src   <= w_cfg_src;
                        r_dst   <= w_cfg_dst;
                        r_count <= w_cfg_len;
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: if (host_gnt_i) r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_data  <= host_rdata_i;
                            r_state <= ST_WR_REQ;
                        end
                    end
                end
                ST_WR_REQ: if (host_gnt_i) r_state <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_src   <= r_src + AddressWidth'(4);
                            r_dst   <= r_dst + AddressWidth'(4);
                            r_count <= r_count - LenWidth'(1);
                            r_state <= (r_count == LenWidth'(1)) ? ST_IDLE : ST_RD_REQ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Host outputs decode straight from the state register so they stay
    // stable for the whole grant wait and are zero whenever idle.
    assign host_req_o   = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
    assign host_we_o    = (r_state == ST_WR_REQ);
    assign host_be_o    = host_req_o ? 4'hF : 4'h0;
    assign host_addr_o  = (r_state == ST_RD_REQ) ? r_src :
                          (r_state == ST_WR_REQ) ? r_dst : '0;
    assign host_wdata_o = (r_state == ST_WR_REQ) ? r_data : '0;

endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - self-checking bench for dma_copy with a behavioural memory model
module tb_dma_copy;
    import dma_copy_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        host_req_o;
    logic        host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_addr_o;
    logic [31:0] host_wdata_o;
    logic        host_gnt_i = 1'b0;
    logic        host_rvalid_i = 1'b0;
    logic [31:0] host_rdata_i = 32'h0;
    logic        host_err_i = 1'b0;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];
    txn_t        txn_q[$];
    txn_t        cur;
    int          gnt_delay = 0;
    int          err_read_n = 0;
    int          read_n = 0;
    int          wait_cnt = 0;
    bit          gnt_drv = 0;
    int          unstable = 0;
    int          req_in_wait = 0;

    dma_copy dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .host_req_o(host_req_o), .host_we_o(host_we_o), .host_be_o(host_be_o),
        .host_addr_o(host_addr_o), .host_wdata_o(host_wdata_o), .host_gnt_i(host_gnt_i),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory responder: grants after gnt_delay cycles of request, answers one cycle after grant.
    always @(negedge clk_i) begin
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        host_rdata_i  = 32'h0;
        if (rst_i) begin
            gnt_drv    = 0;
            host_gnt_i = 1'b0;
            wait_cnt   = 0;
        end else if (gnt_drv) begin
            gnt_drv       = 0;
            host_gnt_i    = 1'b0;
            wait_cnt      = 0;
            txn_q.push_back(cur);
            host_rvalid_i = 1'b1;
            if (host_req_o) req_in_wait++;
            if (cur.we) begin
                mem[cur.addr] = cur.wdata;
            end else begin
                read_n++;
                host_rdata_i = mem.exists(cur.addr) ? mem[cur.addr] : 32'h0;
                if (read_n == err_read_n) host_err_i = 1'b1;
            end
        end else if (host_req_o) begin
            if (wait_cnt == 0) cur = {host_we_o, host_addr_o, host_wdata_o};
            else if (cur != {host_we_o, host_addr_o, host_wdata_o}) unstable++;
            if (host_be_o != 4'hF) unstable++;
            if (wait_cnt >= gnt_delay) begin
                host_gnt_i = 1'b1;
                gnt_drv    = 1;
            end
            wait_cnt++;
        end
    end

    task automatic reg_access(input logic we, input logic [2:0] off, input logic [31:0] wd,
                              input logic [3:0] be, output logic rv, output logic [31:0] rd);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = {27'h0, off, 2'b00}; wdata_i = wd; be_i = be;
        @(negedge clk_i);
        rv = rvalid_o; rd = rdata_o;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'h0;
    endtask

    task automatic wait_done(output bit ok, output logic [31:0] st);
        logic rv;
        ok = 0;
        st = 32'h0;
        for (int n = 0; n < 500; n++) begin
            reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, st);
            if (st[1]) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        txn_q.delete();
        read_n = 0; err_read_n = 0; unstable = 0; req_in_wait = 0;
    endtask

    task automatic test_reset();
        logic rv;
        logic [31:0] rd;
        do_reset();
        checks++;
        if (host_req_o !== 1'b0 || irq_o !== 1'b0 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b irq=%b rvalid=%b required 0", host_req_o, irq_o, rvalid_o);
        end
        for (int r = 0; r < 5; r++) begin
            reg_access(1'b0, 3'(r), 32'h0, 4'hF, rv, rd);
            checks++;
            if (rv !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got rvalid=%b data=%h required 1/0", r, rv, rd);
            end
        end
    endtask

    task automatic test_regs();
        logic rv;
        logic [31:0] rd, v;
        v = $urandom;
        reg_access(1'b1, REG_SRC, v, 4'hF, rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL write_resp: got rvalid=%b data=%h required 1/0", rv, rd);
        end
        reg_access(1'b0, REG_SRC, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== (v & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL src_readback: got %h required %h", rd, v & 32'hFFFF_FFFC);
        end
        reg_access(1'b1, REG_DST, 32'h0, 4'hF, rv, rd);
        reg_access(1'b1, REG_DST, 32'hFFFF_FFFF, 4'b0101, rv, rd);
        reg_access(1'b0, REG_DST, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h00FF_00FC) begin
            errors++;
            $display("FAIL dst_byte_enable: got %h required %h", rd, 32'h00FF_00FC);
        end
        reg_access(1'b1, REG_LEN, 32'hABCD_1234, 4'hF, rv, rd);
        reg_access(1'b0, REG_LEN, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h0000_1234) begin
            errors++;
            $display("FAIL len_width: got %h required %h", rd, 32'h0000_1234);
        end
        reg_access(1'b1, REG_CTRL, 32'h2, 4'hF, rv, rd);
        reg_access(1'b0, REG_CTRL, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL ctrl_readback: got %h required %h", rd, 32'h2);
        end
        reg_access(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, rv, rd);
        reg_access(1'b0, 3'd6, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped: got data=%h err=%b required 0/0", rd, err_o);
        end
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int delay, input logic irq_en, input string tag);
        txn_t exp_q[$];
        logic [31:0] words[$];
        logic [31:0] w, rd;
        logic rv;
        bit ok;
        gnt_delay = delay; err_read_n = 0; read_n = 0; unstable = 0; req_in_wait = 0;
        txn_q.delete();
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            words.push_back(w);
            mem[src + 32'(4 * i)] = w;
            mem[dst + 32'(4 * i)] = ~w;
            exp_q.push_back({1'b0, src + 32'(4 * i), 32'h0});
            exp_q.push_back({1'b1, dst + 32'(4 * i), w});
        end
        reg_access(1'b1, REG_SRC, src, 4'hF, rv, rd);
        reg_access(1'b1, REG_DST, dst, 4'hF, rv, rd);
        reg_access(1'b1, REG_LEN, 32'(len), 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, {30'h0, irq_en, 1'b1}, 4'hF, rv, rd);
        wait_done(ok, rd);
        checks++;
        if (!ok || rd !== 32'h2) begin
            errors++;
            $display("FAIL %s status: got %h done_seen=%0d required 2", tag, rd, ok);
        end
        checks++;
        if (txn_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s txn_count: got %0d required %0d", tag, txn_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++) begin
            checks++;
            if (txn_q[i].we !== exp_q[i].we || txn_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && txn_q[i].wdata !== exp_q[i].wdata)) begin
                errors++;
                $display("FAIL %s txn%0d: got %h required %h", tag, i, txn_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < len; i++) begin
            checks++;
            if (mem[dst + 32'(4 * i)] !== words[i]) begin
                errors++;
                $display("FAIL %s mem%0d: got %h required %h", tag, i, mem[dst + 32'(4 * i)], words[i]);
            end
        end
        checks++;
        if (unstable != 0 || req_in_wait != 0 || irq_o !== irq_en) begin
            errors++;
            $display("FAIL %s handshake: got unstable=%0d req_in_wait=%0d irq=%b required 0/0/%b",
                     tag, unstable, req_in_wait, irq_o, irq_en);
        end
        reg_access(1'b1, REG_STATUS, 32'h6, 4'hF, rv, rd);
    endtask

    task automatic test_copy();
        run_copy(32'h0010_0000, 32'h0010_0400, 4, 0, 1'b1, "copy_basic");
    endtask

    task automatic test_gnt_delay();
        run_copy(32'h0010_0000, 32'h0010_0400, 4, 3, 1'b0, "copy_gnt_delay");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            run_copy(32'h0020_0000 + 32'($urandom_range(0, 63) * 4),
                     32'h0030_0000 + 32'($urandom_range(0, 63) * 4),
                     $urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "copy_random");
        end
        run_copy(32'hFFFF_FFF8, 32'h0050_0000, 3, 1, 1'b0, "copy_wrap");
    endtask

    task automatic test_len_zero();
        logic rv;
        logic [31:0] rd;
        int seen = 0;
        txn_q.delete();
        reg_access(1'b1, REG_LEN, 32'h0, 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, 32'h1, 4'hF, rv, rd);
        reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL len_zero_status: got %h required %h", rd, 32'h2);
        end
        repeat (10) begin
            @(negedge clk_i);
            if (host_req_o) seen++;
        end
        checks++;
        if (seen != 0 || txn_q.size() != 0) begin
            errors++;
            $display("FAIL len_zero_traffic: got %0d req cycles required 0", seen);
        end
        reg_access(1'b1, REG_STATUS, 32'h6, 4'hF, rv, rd);
    endtask

    task automatic test_error();
        logic rv;
        logic [31:0] rd;
        bit ok;
        int writes = 0;
        gnt_delay = 0; read_n = 0; err_read_n = 2; txn_q.delete();
        reg_access(1'b1, REG_SRC, 32'h0010_0000, 4'hF, rv, rd);
        reg_access(1'b1, REG_DST, 32'h0010_0400, 4'hF, rv, rd);
        reg_access(1'b1, REG_LEN, 32'h3, 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, 32'h3, 4'hF, rv, rd);
        wait_done(ok, rd);
        repeat (10) @(negedge clk_i);
        foreach (txn_q[i]) if (txn_q[i].we) writes++;
        checks++;
        if (txn_q.size() != 3 || writes != 1) begin
            errors++;
            $display("FAIL error_traffic: got txns=%0d writes=%0d required 3/1", txn_q.size(), writes);
        end
        reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h6 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL error_status: got status=%h irq=%b required 6/1", rd, irq_o);
        end
        err_read_n = 0;
        reg_access(1'b1, REG_STATUS, 32'h6, 4'hF, rv, rd);
    endtask

    task automatic test_set_wins();
        logic rv;
        logic [31:0] rd;
        bit hit = 0;
        gnt_delay = 0; txn_q.delete();
        reg_access(1'b1, REG_LEN, 32'h2, 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, 32'h1, 4'hF, rv, rd);
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk_i);
            #1;
            if (host_rvalid_i && txn_q.size() == 4 && txn_q[3].we) begin
                hit = 1;
                req_i = 1'b1; we_i = 1'b1; addr_i = {27'h0, REG_STATUS, 2'b00}; wdata_i = 32'h2; be_i = 4'hF;
                @(negedge clk_i);
                req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'h0;
            end
        end
        reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, rd);
        checks++;
        if (!hit || rd !== 32'h2) begin
            errors++;
            $display("FAIL set_wins: got status=%h aligned=%0d required 2", rd, hit);
        end
        reg_access(1'b1, REG_STATUS, 32'h2, 4'hF, rv, rd);
        reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_done: got %h required 0", rd);
        end
    endtask

    task automatic test_busy_writes();
        logic rv;
        logic [31:0] rd;
        bit ok;
        gnt_delay = 3; txn_q.delete();
        reg_access(1'b1, REG_SRC, 32'h0010_0000, 4'hF, rv, rd);
        reg_access(1'b1, REG_DST, 32'h0010_0800, 4'hF, rv, rd);
        reg_access(1'b1, REG_LEN, 32'h4, 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, 32'h3, 4'hF, rv, rd);
        reg_access(1'b1, REG_DST, 32'h5, 4'hF, rv, rd);
        reg_access(1'b1, REG_LEN, 32'h7, 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, 32'h0, 4'hF, rv, rd);
        reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL busy_flag: got %h required 1", rd);
        end
        wait_done(ok, rd);
        reg_access(1'b0, REG_DST, 32'h0, 4'hF, rv, rd);
        checks++;
        if (!ok || rd !== 32'h0010_0800) begin
            errors++;
            $display("FAIL busy_dst: got %h required %h", rd, 32'h0010_0800);
        end
        reg_access(1'b0, REG_LEN, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h4 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_len_irq: got len=%h irq=%b required 4/1", rd, irq_o);
        end
        reg_access(1'b1, REG_STATUS, 32'h2, 4'hF, rv, rd);
        reg_access(1'b0, REG_STATUS, 32'h0, 4'hF, rv, rd);
        checks++;
        if (rd !== 32'h0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL done_clear_irq: got status=%h irq=%b required 0/0", rd, irq_o);
        end
    endtask

    task automatic test_reset_mid();
        logic rv;
        logic [31:0] rd;
        bit hit = 0;
        int seen = 0;
        gnt_delay = 3; txn_q.delete();
        reg_access(1'b1, REG_SRC, 32'h0010_0000, 4'hF, rv, rd);
        reg_access(1'b1, REG_DST, 32'h0010_0400, 4'hF, rv, rd);
        reg_access(1'b1, REG_LEN, 32'h8, 4'hF, rv, rd);
        reg_access(1'b1, REG_CTRL, 32'h3, 4'hF, rv, rd);
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk_i);
            if (host_req_o && host_we_o) hit = 1;
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (!hit || host_req_o !== 1'b0 || irq_o !== 1'b0 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got req=%b irq=%b rvalid=%b wr_seen=%0d required 0/0/0",
                     host_req_o, irq_o, rvalid_o, hit);
        end
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (host_req_o) seen++;
        end
        for (int r = 0; r < 5; r++) begin
            reg_access(1'b0, 3'(r), 32'h0, 4'hF, rv, rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid_reg%0d: got %h required 0", r, rd);
            end
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_traffic: got %0d req cycles required 0", seen);
        end
        txn_q.delete();
    endtask

    initial begin
        test_reset();
        test_regs();
        test_copy();
        test_gnt_delay();
        test_random();
        test_len_zero();
        test_error();
        test_set_wins();
        test_busy_writes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 SHALL have parameter AddressWidth, default 32: bus address width.
REQ-002 SHALL have parameter DataWidth, default 32: bus data width (word = DataWidth bits).
REQ-003 SHALL have parameter LenWidth, default 16: width of the word-count register.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have config-port inputs req_i (1), we_i (1), be_i (4), addr_i (AddressWidth), wdata_i (DataWidth): register-access request as a bus device.
REQ-007 SHALL have config-port outputs rvalid_o (1), rdata_o (DataWidth), err_o (1): register-access response.
REQ-008 SHALL have host-port outputs host_req_o (1), host_we_o (1), host_be_o (4), host_addr_o (AddressWidth), host_wdata_o (DataWidth): initiator request.
REQ-009 SHALL have host-port inputs host_gnt_i (1), host_rvalid_i (1), host_rdata_i (DataWidth), host_err_i (1): initiator grant and response.
REQ-010 SHALL have output irq_o, 1: level interrupt = STATUS.done AND CTRL.irq_en.

Function
REQ-011 Register map by addr_i[4:2]: 0 SRC, 1 DST, 2 LEN (LenWidth bits, words), 3 CTRL (bit0 start, write-only, reads 0; bit1 irq_en), 4 STATUS (bit0 busy RO, bit1 done W1C, bit2 err W1C); other offsets read 0, writes ignored, err_o=0.
REQ-012 Config port SHALL respond rvalid_o=1 exactly one cycle after every req_i, rdata_o registered, zero for writes.
REQ-013 Register writes SHALL honour be_i per byte; SRC/DST bits [1:0] SHALL read back 0.
REQ-014 Writes to SRC, DST, LEN, CTRL while busy SHALL be ignored; STATUS W1C writes SHALL always take effect.
REQ-015 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-016 Writing CTRL.start=1 in IDLE at cycle N SHALL clear done/err, load working src/dst/count, set busy and enter RD_REQ at N+1 (host_req_o=1 at N+1).
REQ-017 Start with LEN=0 SHALL set done in cycle N+1 without bus traffic and stay IDLE.
REQ-018 RD_REQ: host_req_o=1, host_we_o=0, host_be_o=4'hF, host_addr_o=src; request and address held stable until host_gnt_i; on grant go RD_WAIT.
REQ-019 RD_WAIT: host_req_o=0; on host_rvalid_i capture host_rdata_i and go WR_REQ.
REQ-020 WR_REQ: host_req_o=1, host_we_o=1, host_be_o=4'hF, host_addr_o=dst, host_wdata_o=captured word; held until grant; then WR_WAIT.
REQ-021 WR_WAIT: on host_rvalid_i increment src and dst by 4 (wrap modulo 2^AddressWidth), decrement count; count reaching 0 -> IDLE with done=1, busy=0; otherwise RD_REQ next cycle.
REQ-022 At most one host transaction SHALL be outstanding; host_req_o SHALL be 0 in RD_WAIT, WR_WAIT and IDLE.
REQ-023 host_err_i sampled with host_rvalid_i in either WAIT state SHALL abort: err=1, done=1, busy=0, IDLE; no further requests.
REQ-024 W1C of done in the same cycle as hardware setting done SHALL leave done=1 (set wins).

Reset
REQ-025 rst_i high at a clock edge SHALL return FSM to IDLE and zero all registers and outputs (host_req_o=0, rvalid_o=0, irq_o=0), including mid-transfer; a pending host response after reset is ignored.

Structure
REQ-026 Register offsets and the FSM state enum SHALL live in shared package dma_copy_pkg.
REQ-027 Register file and config-port response SHALL be one sub-module, dma_copy_regs; FSM and host port stay in dma_copy.

Verification
REQ-028 SRC=0x100000, DST=0x100400, LEN=4, start; memory responder grants immediately, rvalid 1 cycle later -> 4 read/write pairs, DST words equal SRC words, done=1 after final write rvalid.
REQ-029 Same transfer with host_gnt_i delayed 3 cycles per request -> host_req_o/addr/wdata stable throughout wait, identical data result.
REQ-030 LEN=0, start -> no host_req_o ever, STATUS reads 0x2 after one cycle.
REQ-031 LEN=3, host_err_i on 2nd read response -> exactly 1 write issued, STATUS=0x6, irq_o=1 when irq_en=1.
REQ-032 rst_i asserted in WR_REQ of a LEN=8 transfer -> next cycle host_req_o=0, STATUS=0, all registers 0.
REQ-033 Write DST=0x5 while busy, then after done write STATUS=0x2 -> DST unchanged, done cleared, irq_o drops.
